// File: rtl/mandelbrot_pkg.sv
// Shared definitions for the mandelbrot pixel streamer: FSM encoding and FIFO entry layout.
package mandelbrot_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_ISSUE     = 3'd1,
      ST_WAIT_BUSY = 3'd2,
      ST_WAIT_DONE = 3'd3,
      ST_CAPTURE   = 3'd4
   } state_t;

   localparam int ENTRY_W  = 11;
   localparam int DATA_LSB = 0;
   localparam int DATA_W   = 8;
   localparam int SOF_BIT  = 8;
   localparam int EOL_BIT  = 9;
   localparam int EOF_BIT  = 10;

   function automatic logic [ENTRY_W-1:0] pack_entry(input logic [DATA_W-1:0] data,
                                                     input logic sof,
                                                     input logic eol,
                                                     input logic eof);
      logic [ENTRY_W-1:0] e;
      e                         = '0;
      e[DATA_LSB +: DATA_W]     = data;
      e[SOF_BIT]                = sof;
      e[EOL_BIT]                = eol;
      e[EOF_BIT]                = eof;
      return e;
   endfunction

endpackage

// File: rtl/pixel_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; head is the stored entry at the read pointer.
module pixel_sync_fifo #(
   parameter int WIDTH = 11,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty,
   output logic                     full
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/mandelbrot_pixel_stream.sv
// Paces the iteration engine one pixel at a time, packs two 4-bit codes per byte and streams
// the bytes with frame/line markers; a full FIFO stalls issuing so no pixel is lost.
module mandelbrot_pixel_stream
   import mandelbrot_pkg::*;
#(
   parameter int WIDTH      = 320,
   parameter int HEIGHT     = 240,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          enable,
   input  logic                          running,
   input  logic                          finished,
   input  logic [3:0]                    ctr_out,
   output logic                          run,
   output logic [7:0]                    data_out,
   output logic                          data_valid,
   input  logic                          data_ready,
   output logic                          data_sof,
   output logic                          data_eol,
   output logic                          data_eof,
   output logic                          frame_done,
   output logic [2:0]                    dbg_state,
   output logic [$clog2(FIFO_DEPTH):0]   dbg_fifo_count
);

   localparam int XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
   localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
   localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

   state_t             state;
   state_t             state_nxt;
   logic [XW-1:0]      x;
   logic [YW-1:0]      y;
   logic [3:0]         latch;
   logic               sof_pending;
   logic               last_x;
   logic               last_y;
   logic               push;
   logic               pop;
   logic [ENTRY_W-1:0] push_entry;
   logic [ENTRY_W-1:0] fifo_head;
   logic               fifo_empty;
   logic               fifo_full;

   assign last_x     = (x == X_LAST);
   assign last_y     = (y == Y_LAST);
   assign push       = (state == ST_CAPTURE) && x[0];
   assign push_entry = pack_entry({ctr_out, latch}, sof_pending, last_x, last_x & last_y);

   assign data_valid = ~fifo_empty;
   assign pop        = data_valid & data_ready;
   assign data_out   = data_valid ? fifo_head[DATA_LSB +: DATA_W] : 8'h00;
   assign data_sof   = data_valid & fifo_head[SOF_BIT];
   assign data_eol   = data_valid & fifo_head[EOL_BIT];
   assign data_eof   = data_valid & fifo_head[EOF_BIT];
   assign dbg_state  = state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // A free FIFO slot at issue time guarantees room for the byte this pixel may complete.
   always_comb begin
      state_nxt = state;
      run       = 1'b0;
      case (state)
         ST_IDLE:      if (enable && !running && !fifo_full) state_nxt = ST_ISSUE;
         ST_ISSUE: begin
            run       = 1'b1;
            state_nxt = ST_WAIT_BUSY;
         end
         ST_WAIT_BUSY: if (running)  state_nxt = ST_WAIT_DONE;
         ST_WAIT_DONE: if (!running) state_nxt = ST_CAPTURE;
         ST_CAPTURE:   state_nxt = ST_IDLE;
         default:      state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x           <= '0;
         y           <= '0;
         latch       <= '0;
         sof_pending <= 1'b1;
         frame_done  <= 1'b0;
      end else begin
         frame_done <= pop & fifo_head[EOF_BIT];
         if (state == ST_IDLE && finished) begin
            x           <= '0;
            y           <= '0;
            sof_pending <= 1'b1;
         end
         if (state == ST_CAPTURE) begin
            if (!x[0]) latch <= ctr_out;
            else       sof_pending <= 1'b0;
            if (last_x) begin
               x <= '0;
               if (last_y) begin
                  y           <= '0;
                  sof_pending <= 1'b1;
               end else begin
                  y <= y + YW'(1);
               end
            end else begin
               x <= x + XW'(1);
            end
         end
      end
   end

   pixel_sync_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data (push_entry),
      .pop       (pop),
      .head      (fifo_head),
      .count     (dbg_fifo_count),
      .empty     (fifo_empty),
      .full      (fifo_full)
   );

endmodule

// File: tb/tb_mandelbrot_pixel_stream.sv
// Bench for mandelbrot_pixel_stream: behavioural engine, pixel-order byte model, scoreboard.
module tb_mandelbrot_pixel_stream;
   import mandelbrot_pkg::*;

   localparam int W = 4;
   localparam int H = 2;
   localparam int D = 2;

   // clock / reset
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic       enable = 1'b0;
   logic       running = 1'b0;
   logic       finished = 1'b0;
   logic [3:0] ctr_out = 4'h0;
   logic       data_ready = 1'b0;
   logic       run, data_valid, data_sof, data_eol, data_eof, frame_done;
   logic [7:0] data_out;
   logic [2:0] dbg_state;
   logic [$clog2(D):0] dbg_fifo_count;

   mandelbrot_pixel_stream #(.WIDTH(W), .HEIGHT(H), .FIFO_DEPTH(D)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .running(running), .finished(finished),
      .ctr_out(ctr_out), .run(run), .data_out(data_out), .data_valid(data_valid),
      .data_ready(data_ready), .data_sof(data_sof), .data_eol(data_eol), .data_eof(data_eof),
      .frame_done(frame_done), .dbg_state(dbg_state), .dbg_fifo_count(dbg_fifo_count)
   );

   int checks = 0;
   int errors = 0;
   int run_count = 0;
   int fd_count = 0;

   logic [ENTRY_W-1:0] exp_q[$];
   logic [ENTRY_W-1:0] got_q[$];
   logic [3:0]         code_q[$];

   // Reference model: pixels in raster order, two per byte, markers from frame position.
   int         pix_n = 0;
   logic [3:0] even_code = 4'h0;

   function automatic void model_pixel(input logic [3:0] c);
      int px;
      px = pix_n % W;
      if (px % 2 == 0) even_code = c;
      else exp_q.push_back({(pix_n == W*H-1), (px == W-1), (pix_n == 1), c, even_code});
      pix_n = (pix_n + 1) % (W*H);
   endfunction

   // Behavioural engine: random start delay and busy time after each run pulse.
   int         eng_st = 0;
   int         eng_wait = 0;
   logic [3:0] eng_code = 4'h0;

   always @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         eng_st = 0; running = 1'b0; finished = 1'b0; ctr_out = 4'h0;
         pix_n = 0; exp_q.delete(); code_q.delete();
      end else begin
         case (eng_st)
            0: if (run) begin
               finished = 1'b0;
               eng_code = (code_q.size() > 0) ? code_q.pop_front() : 4'($urandom_range(0, 15));
               eng_wait = $urandom_range(0, 2);
               eng_st   = 1;
            end
            1: if (eng_wait == 0) begin
               running  = 1'b1;
               eng_wait = $urandom_range(0, 3);
               eng_st   = 2;
            end else eng_wait--;
            default: if (eng_wait == 0) begin
               running = 1'b0;
               ctr_out = eng_code;
               if (pix_n == W*H-1) finished = 1'b1;
               model_pixel(eng_code);
               eng_st = 0;
            end else eng_wait--;
         endcase
      end
   end

   // Scoreboard: popped bytes vs model, frame_done timing, head stability under stall.
   logic               fd_expect = 1'b0;
   logic               prev_stall = 1'b0;
   logic [ENTRY_W-1:0] prev_head, cur, e;

   always @(negedge clk) begin
      if (!rst_n) begin
         fd_expect  = 1'b0;
         prev_stall = 1'b0;
      end else begin
         cur = {data_eof, data_eol, data_sof, data_out};
         if (run) run_count++;
         if (frame_done) fd_count++;
         checks++;
         assert (frame_done === fd_expect) else begin
            errors++; $error("FAIL frame_done observed %0b expected %0b", frame_done, fd_expect);
         end
         fd_expect = 1'b0;
         if (prev_stall) begin
            checks++;
            assert (data_valid === 1'b1 && cur === prev_head) else begin
               errors++; $error("FAIL stall_hold observed %03h/%0b expected %03h/1", cur, data_valid, prev_head);
            end
         end
         if (data_valid && data_ready) begin
            got_q.push_back(cur);
            checks++;
            assert (exp_q.size() > 0) else begin
               errors++; $error("FAIL unexpected_byte observed %03h expected none", cur);
            end
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               checks++;
               assert (cur === e) else begin
                  errors++; $error("FAIL byte observed %03h expected %03h", cur, e);
               end
               fd_expect = e[EOF_BIT];
            end
         end
         prev_stall = data_valid && !data_ready;
         prev_head  = cur;
      end
   end

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++; $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic do_reset();
      enable = 1'b0;
      rst_n  = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic wait_got(input int n, input int budget, input string tag);
      int i;
      i = 0;
      while (got_q.size() < n && i < budget) begin tick(); i++; end
      chk(tag, (got_q.size() >= n), 1);
   endtask

   task automatic quiesce(input string tag);
      int i;
      enable = 1'b0;
      i = 0;
      while (!(dbg_state == ST_IDLE && eng_st == 0 && !running && exp_q.size() == 0 && !data_valid)
             && i < 400) begin
         tick(); i++;
      end
      chk(tag, (i < 400), 1);
   endtask

   task automatic load_codes_1_to_8();
      for (int i = 1; i <= 8; i++) code_q.push_back(4'(i));
   endtask

   logic [ENTRY_W-1:0] g;
   int r0, r1, fd0, par, i;

   initial begin
      // 1: reset values, no run pulse while disabled
      repeat (3) tick();
      chk("rst_run", run, 0);
      chk("rst_valid", data_valid, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_data", data_out, 0);
      chk("rst_markers", {data_sof, data_eol, data_eof}, 0);
      chk("rst_state", dbg_state, ST_IDLE);
      chk("rst_fifo_count", dbg_fifo_count, 0);
      rst_n = 1'b1;
      repeat (10) tick();
      chk("idle_no_run", run_count, 0);

      // 2: one frame with codes 1..8
      got_q.delete();
      load_codes_1_to_8();
      fd0 = fd_count;
      data_ready = 1'b1;
      enable = 1'b1;
      wait_got(4, 400, "frame_timeout");
      tick(); tick();
      enable = 1'b0;
      chk("frame_b0", got_q[0], 11'h121);
      chk("frame_b1", got_q[1], 11'h243);
      chk("frame_b2", got_q[2], 11'h065);
      chk("frame_b3", got_q[3], 11'h687);
      chk("frame_done_count", fd_count - fd0, 1);
      quiesce("frame_quiesce");

      // 3: backpressure holds issuing once the FIFO is full
      data_ready = 1'b0;
      got_q.delete();
      par = pix_n % 2;
      r0 = run_count;
      enable = 1'b1;
      repeat (80) tick();
      r1 = run_count;
      repeat (40) tick();
      chk("bp_runs", r1 - r0, (par != 0) ? 3 : 4);
      chk("bp_no_more_runs", run_count, r1);
      chk("bp_valid", data_valid, 1);
      chk("bp_fifo_count", dbg_fifo_count, 2);
      chk("bp_model_pending", exp_q.size(), 2);
      enable = 1'b0;
      data_ready = 1'b1;
      quiesce("bp_quiesce");
      chk("bp_drained", got_q.size(), 2);

      // 4: enable dropped after pixel 1 issued
      do_reset();
      data_ready = 1'b1;
      got_q.delete();
      load_codes_1_to_8();
      r0 = run_count;
      enable = 1'b1;
      i = 0;
      while (run_count - r0 < 2 && i < 100) begin tick(); i++; end
      enable = 1'b0;
      chk("en_two_issued", (i < 100), 1);
      repeat (40) tick();
      chk("en_runs", run_count - r0, 2);
      chk("en_byte_count", got_q.size(), 1);
      chk("en_b0", got_q[0], 11'h121);
      chk("en_state_idle", dbg_state, ST_IDLE);
      enable = 1'b1;
      wait_got(4, 400, "en_resume_timeout");
      enable = 1'b0;
      quiesce("en_quiesce");
      chk("en_b1", got_q[1], 11'h243);
      chk("en_b2", got_q[2], 11'h065);
      chk("en_b3", got_q[3], 11'h687);

      // 5: continuous frames with random codes
      do_reset();
      got_q.delete();
      fd0 = fd_count;
      enable = 1'b1;
      wait_got(8, 1500, "cont_timeout");
      tick(); tick();
      enable = 1'b0;
      quiesce("cont_quiesce");
      g = got_q[0]; chk("cont_sof0", g[SOF_BIT], 1);
      g = got_q[2]; chk("cont_sof2", g[SOF_BIT], 0);
      g = got_q[3]; chk("cont_eof3", g[EOF_BIT], 1);
      g = got_q[4]; chk("cont_sof4", g[SOF_BIT], 1);
      g = got_q[5]; chk("cont_eol5", g[EOL_BIT], 1);
      g = got_q[7]; chk("cont_eof7", g[EOF_BIT], 1);
      chk("cont_frame_done", fd_count - fd0, 2);

      // 6: asynchronous reset while waiting on the engine
      do_reset();
      got_q.delete();
      enable = 1'b1;
      i = 0;
      while (dbg_state != ST_WAIT_DONE && i < 100) begin tick(); i++; end
      chk("ar_reached_wait_done", (i < 100), 1);
      rst_n = 1'b0;
      #1;
      chk("ar_state", dbg_state, ST_IDLE);
      chk("ar_run", run, 0);
      chk("ar_valid", data_valid, 0);
      chk("ar_fifo_count", dbg_fifo_count, 0);
      chk("ar_frame_done", frame_done, 0);
      repeat (2) tick();
      rst_n = 1'b1;
      got_q.delete();
      wait_got(1, 400, "ar_restart_timeout");
      g = got_q[0]; chk("ar_first_sof", g[SOF_BIT], 1);
      enable = 1'b0;
      quiesce("ar_quiesce");

      // final report
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog observed timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
